// File: rtl/input_layer_pkg.sv
// Shared types and constants for the input-layer int8->fp8 cast path.
package input_layer_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int FP8_EXP_BIAS = 15;
  localparam int FP8_EXP_W    = 5;
  localparam int FP8_MANT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/input_layer_ctrl_int2float8.sv
// Unsigned int8 -> fp8 (1/5/2) converter or pass-through, one registered stage.
// Latency 1 cycle, free-running: no stall input, the caller decides when a result is used.
module int2float8
  import input_layer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cast_,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0]            out_q, out_d;
  logic [2:0]            lead;
  logic [10:0]           ext;
  logic [FP8_MANT_W:0]   m3;
  logic [FP8_EXP_W-1:0]  exp_v;
  logic [8:0]            v9, rnd;

  always_comb begin
    lead = '0;
    for (int i = 0; i < 8; i++) begin
      if (in_byte[i]) lead = 3'(i);
    end
    // three bits below the leading one, zero-filled when they run off the bottom
    ext   = {in_byte, 3'b000};
    m3    = ext[lead +: 3];
    exp_v = FP8_EXP_W'(FP8_EXP_BIAS) + FP8_EXP_W'(lead);
    v9    = {1'b0, exp_v, m3};
    rnd   = (v9[7:0] == 8'hFF) ? v9 : v9 + 9'd1;
    out_d = in_byte;
    if (cast_) out_d = (in_byte == 8'h00) ? 8'h00 : rnd[8:1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  assign out_byte = out_q;

endmodule

// File: rtl/input_layer_ctrl.sv
// Frame sequencer: one input word -> four bytes through a single int2float8 -> one packed output word.
// Latency 6 cycles from input handshake to out_valid; out_ready only holds the OUT state.
module input_layer_ctrl
  import input_layer_pkg::*;
#(
  parameter int WPR_W  = 10,
  parameter int ROWS_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_cast,
  input  logic [WPR_W-1:0]  cfg_wpr,
  input  logic [ROWS_W-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_eol,
  output logic              out_eof
);

  state_e              state_q, state_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         pack_q, pack_d;
  logic [1:0]          k_q, k_d;
  logic                wr_vld_q, wr_vld_d;
  logic [1:0]          wr_idx_q, wr_idx_d;
  logic [WPR_W-1:0]    col_q, col_d, wpr_q, wpr_d;
  logic [ROWS_W-1:0]   row_q, row_d, rows_q, rows_d;
  logic                cast_q, cast_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic                eol_q, eol_d, eof_q, eof_d;
  logic                eol_now, eof_now;
  logic [7:0]          conv_in, conv_out;

  int2float8 u_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .cast_    (cast_q),
    .in_byte  (conv_in),
    .out_byte (conv_out)
  );

  assign conv_in = (state_q == ST_CONV) ? shift_q[7:0] : 8'h00;
  assign eol_now = (col_q == wpr_q - WPR_W'(1));
  assign eof_now = eol_now && (row_q == rows_q - ROWS_W'(1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    pack_d   = pack_q;
    k_d      = k_q;
    wr_vld_d = 1'b0;
    wr_idx_d = k_q;
    col_d    = col_q;
    row_d    = row_q;
    wpr_d    = wpr_q;
    rows_d   = rows_q;
    cast_d   = cast_q;
    eol_d    = eol_q;
    eof_d    = eof_q;

    // result of the byte issued last cycle lands in its pack slot
    if (wr_vld_q) pack_d[{wr_idx_q, 3'b000} +: 8] = conv_out;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          cast_d  = cfg_cast;
          wpr_d   = cfg_wpr;
          rows_d  = cfg_rows;
          col_d   = '0;
          row_d   = '0;
          state_d = (cfg_wpr == '0 || cfg_rows == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          shift_d = in_data;
          k_d     = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        wr_vld_d = 1'b1;
        shift_d  = shift_q >> 8;
        k_d      = k_q + 2'd1;
        if (k_q == 2'(PIX_PER_WORD - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        eol_d   = eol_now;
        eof_d   = eof_now;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (eol_now) begin
            col_d = '0;
            row_d = row_q + ROWS_W'(1);
          end else begin
            col_d = col_q + WPR_W'(1);
          end
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          state_d = eof_q ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_LOAD) || (state_d == ST_CONV) ||
                  (state_d == ST_DRAIN) || (state_d == ST_OUT);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      pack_q      <= '0;
      k_q         <= '0;
      wr_vld_q    <= 1'b0;
      wr_idx_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wpr_q       <= '0;
      rows_q      <= '0;
      cast_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pack_q      <= pack_d;
      k_q         <= k_d;
      wr_vld_q    <= wr_vld_d;
      wr_idx_q    <= wr_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wpr_q       <= wpr_d;
      rows_q      <= rows_d;
      cast_q      <= cast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = pack_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_input_layer_ctrl.sv
// Randomized bench for input_layer_ctrl against a behavioural fp8 model and frame scoreboard.
module tb_input_layer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start, cfg_cast;
  logic [9:0]  cfg_wpr, cfg_rows;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_eol, out_eof;

  int tests_run = 0;
  int fails     = 0;

  input_layer_ctrl #(.WPR_W(10), .ROWS_W(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_start (cfg_start),
    .cfg_cast  (cfg_cast),
    .cfg_wpr   (cfg_wpr),
    .cfg_rows  (cfg_rows),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // fp8 value from plain arithmetic: exponent from magnitude, three fraction bits, round up by one LSB
  function automatic logic [7:0] ref_byte(input int x, input bit cast);
    int p, m3, v;
    if (!cast) return 8'(x);
    if (x == 0) return 8'h00;
    p = 0;
    while ((x >> (p + 1)) != 0) p++;
    m3 = ((x * 8) >> p) - 8;
    v  = (15 + p) * 8 + m3;
    if ((v % 256) != 255) v = v + 1;
    return 8'(v / 2);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input bit cast);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = ref_byte(int'(w[b*8 +: 8]), cast);
    return r;
  endfunction

  task automatic pulse_start(input bit cast, input int wpr, input int rows);
    cfg_cast  = cast;
    cfg_wpr   = 10'(wpr);
    cfg_rows  = 10'(rows);
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cfg_cast  = 1'($urandom);
    cfg_wpr   = 10'($urandom);
    cfg_rows  = 10'($urandom);
  endtask

  task automatic run_frame(input bit cast, input int wpr, input int rows, input bit use_fixed,
                           input logic [31:0] fixed, input int vld_pct, input int rdy_pct,
                           input int stall, input int spurious_at, output int cycles);
    logic [31:0] q[$];
    logic [31:0] exp_w, hold_d;
    logic        hold_l, hold_f;
    int total, n_in, n_out, dones, cyc, since;
    bit hs, stalled;
    total = wpr * rows;
    n_in = 0; n_out = 0; dones = 0; cyc = 0; since = 0; stalled = 0;
    pulse_start(cast, wpr, rows);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL busy_rise: busy=%b required 1", busy);
    end
    while (dones == 0 && cyc < 3000) begin
      cyc++;
      hs = 0;
      if (out_valid && stall > 0 && !stalled) begin
        stalled  = 1;
        hold_d   = out_data; hold_l = out_eol; hold_f = out_eof;
        out_ready = 1'b0; in_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick; cyc++;
          tests_run++;
          if (out_valid !== 1'b1 || out_data !== hold_d || out_eol !== hold_l ||
              out_eof !== hold_f || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold cycle %0d: vld=%b data=%h eol=%b eof=%b in_ready=%b required 1 %h %b %b 0",
                     s, out_valid, out_data, out_eol, out_eof, in_ready, hold_d, hold_l, hold_f);
          end
        end
      end
      if (cyc == spurious_at) begin
        cfg_start = 1'b1; cfg_wpr = 10'd7; cfg_rows = 10'd7; cfg_cast = ~cast;
      end else begin
        cfg_start = 1'b0;
      end
      in_valid = (n_in < total) && (($urandom % 100) < vld_pct);
      in_data  = use_fixed ? fixed : $urandom;
      if (in_valid && in_ready) begin
        q.push_back(ref_word(in_data, cast));
        n_in++;
      end
      out_ready = (($urandom % 100) < rdy_pct);
      if (out_valid && out_ready) begin
        hs = 1;
        exp_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        tests_run++;
        if (out_data !== exp_w || out_eol !== ((n_out % wpr) == wpr - 1) ||
            out_eof !== (n_out == total - 1)) begin
          fails++;
          $display("FAIL word %0d: data=%h eol=%b eof=%b required %h %b %b", n_out,
                   out_data, out_eol, out_eof, exp_w, (n_out % wpr) == wpr - 1, n_out == total - 1);
        end
        n_out++;
      end
      tick;
      since = hs ? 1 : since + 1;
      if (done) begin
        dones++;
        tests_run++;
        if (since !== 1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL done_timing: cycles_after_last_out=%0d busy=%b required 1 0", since, busy);
        end
      end
    end
    cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycles = cyc;
    tests_run++;
    if (dones != 1 || n_out != total || q.size() != 0) begin
      fails++;
      $display("FAIL frame_count: done=%0d words=%0d pending=%0d required 1 %0d 0", dones, n_out, total, q.size());
    end
    tick;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL after_frame: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if ({busy, done, in_ready, out_valid, out_eol, out_eof} !== 6'b0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL %s: busy=%b done=%b in_ready=%b out_valid=%b eol=%b eof=%b data=%h required all 0",
               tag, busy, done, in_ready, out_valid, out_eol, out_eof, out_data);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cfg_start = 0; cfg_cast = 0; cfg_wpr = 0; cfg_rows = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    tick; tick;
    check_all_zero("reset_state");
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_cast_latency;
    int n;
    pulse_start(1'b1, 1, 1);
    n = 0;
    while (!in_ready && n < 10) begin tick; n++; end
    in_valid = 1'b1; in_data = 32'hFF80_0301; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin tick; n++; end
    tests_run++;
    if (n !== 6) begin fails++; $display("FAIL cast_latency: %0d cycles required 6", n); end
    tests_run++;
    if (out_data !== 32'h5C58_423C || out_eol !== 1'b1 || out_eof !== 1'b1) begin
      fails++; $display("FAIL cast_value: data=%h eol=%b eof=%b required 5c58423c 1 1", out_data, out_eol, out_eof);
    end
    tick;
    tests_run++;
    if (done !== 1'b1) begin fails++; $display("FAIL cast_done: done=%b required 1", done); end
    out_ready = 1'b0;
    tick;
  endtask

  task automatic test_pass_and_zero;
    int c;
    run_frame(1'b0, 1, 1, 1'b1, 32'h7F3C_0000, 100, 100, 0, -1, c);
    run_frame(1'b1, 1, 1, 1'b1, 32'h0000_0000, 100, 100, 0, -1, c);
    run_frame(1'b0, 2, 2, 1'b0, 32'h0, 70, 70, 0, -1, c);
  endtask

  task automatic test_frame_random;
    int c;
    run_frame(1'b1, 3, 2, 1'b0, 32'h0, 60, 60, 0, -1, c);
    run_frame(1'b1, 4, 3, 1'b0, 32'h0, 40, 80, 0, -1, c);
  endtask

  task automatic test_back_to_back;
    int c;
    run_frame(1'b1, 4, 1, 1'b0, 32'h0, 100, 100, 0, -1, c);
    tests_run++;
    if (c !== 28) begin fails++; $display("FAIL word_period: %0d cycles for 4 words required 28", c); end
  endtask

  task automatic test_backpressure;
    int c;
    run_frame(1'b1, 2, 1, 1'b0, 32'h0, 100, 100, 10, -1, c);
  endtask

  task automatic test_degenerate;
    int dones, first, rdy_seen, busy_seen;
    for (int cfg = 0; cfg < 2; cfg++) begin
      pulse_start(1'b1, (cfg == 0) ? 0 : 3, (cfg == 0) ? 2 : 0);
      dones = 0; first = 0; rdy_seen = 0; busy_seen = 0;
      for (int n = 1; n <= 6; n++) begin
        if (done) begin dones++; if (first == 0) first = n; end
        if (in_ready) rdy_seen++;
        if (busy) busy_seen++;
        if (n < 6) tick;
      end
      tests_run++;
      if (dones != 1 || first < 1 || first > 2 || rdy_seen != 0 || busy_seen != 0) begin
        fails++;
        $display("FAIL degenerate cfg%0d: done_pulses=%0d first=%0d in_ready=%0d busy=%0d required 1 1..2 0 0",
                 cfg, dones, first, rdy_seen, busy_seen);
      end
    end
  endtask

  task automatic test_start_ignored;
    int c;
    run_frame(1'b1, 1, 1, 1'b0, 32'h0, 50, 100, 0, 2, c);
    run_frame(1'b1, 2, 1, 1'b0, 32'h0, 100, 100, 0, 5, c);
  endtask

  task automatic test_reset_midframe;
    int c;
    pulse_start(1'b1, 1, 1);
    in_valid = 1'b1; in_data = 32'hAAAA_5555;
    tick;
    in_valid = 1'b0;
    tick;
    reset_n = 1'b0;
    tick;
    check_all_zero("reset_midframe");
    reset_n = 1'b1;
    tick; tick; tick; tick; tick; tick;
    check_all_zero("reset_discard");
    run_frame(1'b1, 1, 1, 1'b1, 32'h0101_0101, 100, 100, 0, -1, c);
  endtask

  initial begin
    test_reset;
    test_cast_latency;
    test_pass_and_zero;
    test_frame_random;
    test_back_to_back;
    test_backpressure;
    test_degenerate;
    test_start_ignored;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
